hazard_unit: RTL and testbench

Pipeline hazard unit for the five-stage MIPS core. It consumes the per-stage control bits the controller pipelines (regwriteE/M/W, memtoRegE/M, branchM, jumpD) together with register addresses from the datapath. It returns stall, flush and forwarding controls, including the flushE/flushM inputs the controller expects. It also owns the data-memory wait-state handshake, freezing the pipeline while a multi-cycle load or store is outstanding.

---
 rtl/hazard_pkg.sv | 44 ++++
 rtl/hazard_unit_mem_wait_fsm.sv | 69 ++++++
 rtl/hazard_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the five-stage MIPS pipeline hazard unit:
//   - REG_AW           : register-address width
//   - mem_state_e      : data-memory wait FSM encoding (MEM_IDLE / MEM_WAIT)
//   - FWD_RF/FWD_W/FWD_M : ALU operand forward-select codes
//   - fwd_sel()        : forward-select resolution for one source operand
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [0:0] {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // The M stage holds the younger result, so it wins over W. Register 0 is
   // hard-wired and must never be forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              regwrite_m,
      input logic [REG_AW-1:0] writereg_m,
      input logic              regwrite_w,
      input logic [REG_AW-1:0] writereg_w
   );
      logic [1:0] sel;
      if (src == {REG_AW{1'b0}}) begin
         sel = FWD_RF;
      end else if (regwrite_m && (writereg_m == src)) begin
         sel = FWD_M;
      end else if (regwrite_w && (writereg_w == src)) begin
         sel = FWD_W;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_unit_mem_wait_fsm.sv
// -----------------------------------------------------------------------------
// mem_wait_fsm
// Data-memory wait-state handshake. Tracks whether a load/store in M is
// waiting on the data memory and produces the request and pipeline-freeze
// indication.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   mem_read_i       : load in M (memtoRegM)
//   mem_write_i      : store in M (memWriteM)
//   dmem_ready_i     : memory completes the access this cycle
//   dmem_req_o       : data-memory access request
//   mem_stall_o      : freeze the pipeline this cycle
// -----------------------------------------------------------------------------
module mem_wait_fsm
   import hazard_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic mem_read_i,
   input  logic mem_write_i,
   input  logic dmem_ready_i,
   output logic dmem_req_o,
   output logic mem_stall_o
);

   mem_state_e state_q;
   mem_state_e state_d;
   logic       mem_req_s;

   assign mem_req_s = mem_read_i | mem_write_i;

   // State register; reset forces IDLE immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MEM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and outputs. The freeze depends only on the live request and
   // ready, so a zero-wait access (ready already high) costs no cycle and the
   // freeze still follows the request inputs while reset is held.
   always_comb begin
      state_d     = state_q;
      dmem_req_o  = mem_req_s;
      mem_stall_o = mem_req_s & ~dmem_ready_i;
      case (state_q)
         MEM_IDLE: begin
            if (mem_req_s && !dmem_ready_i) begin
               state_d = MEM_WAIT;
            end else begin
               state_d = MEM_IDLE;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready_i) begin
               state_d = MEM_IDLE;
            end else begin
               state_d = MEM_WAIT;
            end
         end
         default: begin
            state_d = MEM_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard unit for the five-stage MIPS core: load-use stall, branch /
// jump flush, EX operand forwarding and data-memory wait-state freeze.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   rsD, rtD, rsE, rtE          : source registers in D and E
//   writeregE/M/W, regwriteE/M/W: destination register and write enable
//   memtoRegE/M, memWriteM      : load in E/M, store in M
//   jumpD, branchTakenM         : jump in D, taken branch resolved in M
//   dmem_ready / dmem_req       : data-memory handshake
//   stallF..stallM              : hold PC / IF-ID / ID-EX / EX-MEM
//   flushD..flushW              : clear IF-ID / ID-EX / EX-MEM / MEM-WB
//   forwardAE, forwardBE        : ALU operand select (00 RF, 01 W, 10 M)
// Optional feature (macro HAZARD_PERF_EN): adds stall_cycles and flush_events
// 32-bit wrapping performance counters.
// -----------------------------------------------------------------------------
module hazard_unit
   import hazard_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rsD,
   input  logic [REG_AW-1:0] rtD,
   input  logic [REG_AW-1:0] rsE,
   input  logic [REG_AW-1:0] rtE,
   input  logic [REG_AW-1:0] writeregE,
   input  logic [REG_AW-1:0] writeregM,
   input  logic [REG_AW-1:0] writeregW,
   input  logic              regwriteE,
   input  logic              regwriteM,
   input  logic              regwriteW,
   input  logic              memtoRegE,
   input  logic              memtoRegM,
   input  logic              memWriteM,
   input  logic              jumpD,
   input  logic              branchTakenM,
   input  logic              dmem_ready,
   output logic              dmem_req,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              flushD,
   output logic              flushE,
   output logic              flushM,
   output logic              flushW,
   output logic [1:0]        forwardAE,
   output logic [1:0]        forwardBE
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_events
`endif
);

   logic mem_stall_s;
   logic lwstall_s;

   mem_wait_fsm u_mem_fsm (
      .clk          (clk),
      .rst_n        (rst),
      .mem_read_i   (memtoRegM),
      .mem_write_i  (memWriteM),
      .dmem_ready_i (dmem_ready),
      .dmem_req_o   (dmem_req),
      .mem_stall_o  (mem_stall_s)
   );

   // Load in E whose result is needed by the instruction in D.
   assign lwstall_s = memtoRegE & regwriteE & (writeregE != {REG_AW{1'b0}}) &
                      ((writeregE == rsD) | (writeregE == rtD));

   // Priority: memory freeze > taken branch > load-use > jump. A load-use
   // stall beats the jump so the jump is simply re-seen next cycle.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      flushW = 1'b0;
      if (mem_stall_s) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else if (branchTakenM) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
      end else if (lwstall_s) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end else if (jumpD) begin
         flushD = 1'b1;
      end else begin
         flushD = 1'b0;
      end
   end

   // Forwarding keeps working during a stall.
   always_comb begin
      forwardAE = fwd_sel(rsE, regwriteM, writeregM, regwriteW, writeregW);
      forwardBE = fwd_sel(rtE, regwriteM, writeregM, regwriteW, writeregW);
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] stall_cycles_d;
   logic [31:0] flush_events_q;
   logic [31:0] flush_events_d;

   // Counter next-state; both wrap naturally at 2^32.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (stallF | stallD | stallE | stallM) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
      if (flushD | flushE) begin
         flush_events_d = flush_events_q + 32'd1;
      end else begin
         flush_events_d = flush_events_q;
      end
   end

   // Counter registers; held at zero while reset is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= 32'd0;
         flush_events_q <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
   import hazard_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic              regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM;
   logic              memWriteM, jumpD, branchTakenM, dmem_ready;
   logic              dmem_req, stallF, stallD, stallE, stallM;
   logic              flushD, flushE, flushM, flushW;
   logic [1:0]        forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
   logic [31:0]       stall_cycles, flush_events;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   hazard_unit dut (
      .clk(clk), .rst(rst),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .memtoRegE(memtoRegE), .memtoRegM(memtoRegM), .memWriteM(memWriteM),
      .jumpD(jumpD), .branchTakenM(branchTakenM), .dmem_ready(dmem_ready),
      .dmem_req(dmem_req),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .forwardAE(forwardAE), .forwardBE(forwardBE)
`ifdef HAZARD_PERF_EN
      , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
   );

   always #5 clk = ~clk;

   // Packed view: {req, stallF,D,E,M, flushD,E,M,W, fwdA, fwdB}
   function automatic logic [12:0] obs_vec();
      return {dmem_req, stallF, stallD, stallE, stallM,
              flushD, flushE, flushM, flushW, forwardAE, forwardBE};
   endfunction

   function automatic logic [1:0] fwd_model(input logic [REG_AW-1:0] src);
      if (src != 0 && regwriteM && writeregM == src) return 2'd2;
      if (src != 0 && regwriteW && writeregW == src) return 2'd1;
      return 2'd0;
   endfunction

   // Reference model: pick the winning hazard, then derive how many front
   // stages freeze and which stages are cleared.
   function automatic logic [12:0] model_vec();
      bit       req, busy, lu;
      int       depth;
      bit [3:0] st;      // F,D,E,M
      bit [3:0] fl;      // D,E,M,W
      req  = memtoRegM || memWriteM;
      busy = req && !dmem_ready;
      lu   = memtoRegE && regwriteE && writeregE != 0 &&
             (writeregE == rsD || writeregE == rtD);
      depth = 0;
      fl    = 4'b0000;
      if (busy)              begin depth = 4; fl = 4'b0001; end
      else if (branchTakenM) begin depth = 0; fl = 4'b1110; end
      else if (lu)           begin depth = 2; fl = 4'b0100; end
      else if (jumpD)        begin depth = 0; fl = 4'b1000; end
      for (int i = 0; i < 4; i++) st[3-i] = (i < depth);
      return {req, st, fl, fwd_model(rsE), fwd_model(rtE)};
   endfunction

   function automatic bit dut_in_wait();
      return dut.u_mem_fsm.state_q == MEM_WAIT;
   endfunction

   task automatic zero_inputs();
      rsD = 0; rtD = 0; rsE = 0; rtE = 0;
      writeregE = 0; writeregM = 0; writeregW = 0;
      regwriteE = 0; regwriteM = 0; regwriteW = 0;
      memtoRegE = 0; memtoRegM = 0; memWriteM = 0;
      jumpD = 0; branchTakenM = 0; dmem_ready = 0;
   endtask

   task automatic pulse_reset();
      @(negedge clk); zero_inputs(); rst = 0; #1;
      @(negedge clk); rst = 1;
   endtask

   task automatic test_reset();
      zero_inputs(); rst = 0; #1;
      n_checks++;
      if (obs_vec() !== 13'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs_vec(), 13'd0);
      end
      n_checks++;
      if (dut_in_wait() !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: got WAIT expected IDLE");
      end
`ifdef HAZARD_PERF_EN
      n_checks++;
      if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
         n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_events);
      end
`endif
      @(negedge clk); rst = 1;
   endtask

   task automatic test_load_use();
      @(negedge clk); zero_inputs();
      memtoRegE = 1; regwriteE = 1; writeregE = 2; rsD = 2; rtD = 4; #1;
      n_checks++;
      if (obs_vec() !== 13'b0_1100_0100_00_00) begin
         n_fail++; $display("FAIL load_use_stall: got %b expected %b", obs_vec(), 13'b0_1100_0100_00_00);
      end
      // lw now in W, add in E
      @(negedge clk); zero_inputs();
      regwriteW = 1; writeregW = 2; rsE = 2; rtE = 4; #1;
      n_checks++;
      if (forwardAE !== 2'b01 || forwardBE !== 2'b00) begin
         n_fail++; $display("FAIL load_use_fwd: got %b/%b expected 01/00", forwardAE, forwardBE);
      end
      // Register 0 destination never stalls
      @(negedge clk); zero_inputs();
      memtoRegE = 1; regwriteE = 1; writeregE = 0; rsD = 0; rtD = 0; #1;
      n_checks++;
      if (obs_vec() !== 13'd0) begin
         n_fail++; $display("FAIL load_use_r0: got %b expected %b", obs_vec(), 13'd0);
      end
   endtask

   task automatic test_forwarding();
      @(negedge clk); zero_inputs();
      regwriteM = 1; regwriteW = 1; writeregM = 5; writeregW = 5; rsE = 5; rtE = 5; #1;
      n_checks++;
      if (forwardAE !== 2'b10 || forwardBE !== 2'b10) begin
         n_fail++; $display("FAIL fwd_m_priority: got %b/%b expected 10/10", forwardAE, forwardBE);
      end
      writeregM = 0; rsE = 0; rtE = 5; #1;
      n_checks++;
      if (forwardAE !== 2'b00 || forwardBE !== 2'b01) begin
         n_fail++; $display("FAIL fwd_r0_and_w: got %b/%b expected 00/01", forwardAE, forwardBE);
      end
   endtask

   task automatic test_mem_wait();
      @(negedge clk); zero_inputs();
      memtoRegM = 1; regwriteM = 1; writeregM = 3; dmem_ready = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (obs_vec() !== 13'b1_1111_0001_00_00) begin
            n_fail++; $display("FAIL mem_wait_cycle%0d: got %b expected %b", c, obs_vec(), 13'b1_1111_0001_00_00);
         end
         if (c > 0) begin
            n_checks++;
            if (dut_in_wait() !== 1'b1) begin
               n_fail++; $display("FAIL mem_wait_state%0d: got IDLE expected WAIT", c);
            end
         end
         @(negedge clk);
      end
      dmem_ready = 1; #1;
      n_checks++;
      if (obs_vec() !== 13'b1_0000_0000_00_00 || dut_in_wait() !== 1'b1) begin
         n_fail++; $display("FAIL mem_release: got %b wait=%b expected %b wait=1", obs_vec(), dut_in_wait(), 13'b1_0000_0000_00_00);
      end
      @(negedge clk); zero_inputs(); #1;
      n_checks++;
      if (dut_in_wait() !== 1'b0) begin
         n_fail++; $display("FAIL mem_back_idle: got WAIT expected IDLE");
      end
   endtask

   task automatic test_branch_priority();
      @(negedge clk); zero_inputs();
      memtoRegE = 1; regwriteE = 1; writeregE = 2; rsD = 2; branchTakenM = 1; jumpD = 1; #1;
      n_checks++;
      if (obs_vec() !== 13'b0_0000_1110_00_00) begin
         n_fail++; $display("FAIL branch_over_lw: got %b expected %b", obs_vec(), 13'b0_0000_1110_00_00);
      end
      branchTakenM = 0; #1;
      n_checks++;
      if (obs_vec() !== 13'b0_1100_0100_00_00) begin
         n_fail++; $display("FAIL lw_over_jump: got %b expected %b", obs_vec(), 13'b0_1100_0100_00_00);
      end
      memtoRegM = 1; branchTakenM = 1; #1;
      n_checks++;
      if (obs_vec() !== 13'b1_1111_0001_00_00) begin
         n_fail++; $display("FAIL mem_over_branch: got %b expected %b", obs_vec(), 13'b1_1111_0001_00_00);
      end
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk); zero_inputs(); memtoRegM = 1; dmem_ready = 0;
      @(negedge clk); #1;
      n_checks++;
      if (dut_in_wait() !== 1'b1) begin
         n_fail++; $display("FAIL rst_wait_enter: got IDLE expected WAIT");
      end
      memtoRegM = 0; rst = 0; #1;
      n_checks++;
      if (obs_vec() !== 13'd0 || dut_in_wait() !== 1'b0) begin
         n_fail++; $display("FAIL rst_in_wait: got %b wait=%b expected 0 wait=0", obs_vec(), dut_in_wait());
      end
      @(negedge clk); rst = 1;
      @(negedge clk); #1;
      n_checks++;
      if (dut_in_wait() !== 1'b0) begin
         n_fail++; $display("FAIL rst_after_rise: got WAIT expected IDLE");
      end
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      pulse_reset();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); zero_inputs();
         memtoRegE = 1; regwriteE = 1; writeregE = 7; rtD = 7;
         @(negedge clk); zero_inputs();
      end
      memtoRegM = 1;
      repeat (3) @(negedge clk);
      dmem_ready = 1;
      @(negedge clk); zero_inputs(); #1;
      n_checks++;
      if (stall_cycles !== 32'd5 || flush_events !== 32'd2) begin
         n_fail++; $display("FAIL perf_stalls: got %0d/%0d expected 5/2", stall_cycles, flush_events);
      end
      pulse_reset();
      @(negedge clk); zero_inputs(); branchTakenM = 1;
      @(negedge clk); zero_inputs(); jumpD = 1;
      @(negedge clk); zero_inputs(); #1;
      n_checks++;
      if (stall_cycles !== 32'd0 || flush_events !== 32'd2) begin
         n_fail++; $display("FAIL perf_flushes: got %0d/%0d expected 0/2", stall_cycles, flush_events);
      end
   endtask
`endif

   task automatic test_random();
      logic [12:0] exp;
      bit          m_wait;
      int unsigned m_stalls, m_flushes;
      pulse_reset();
      m_wait = 0; m_stalls = 0; m_flushes = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 15) != 0);
         rsD = REG_AW'($urandom_range(0, 3)); rtD = REG_AW'($urandom_range(0, 3));
         rsE = REG_AW'($urandom_range(0, 3)); rtE = REG_AW'($urandom_range(0, 3));
         writeregE = REG_AW'($urandom_range(0, 3));
         writeregM = REG_AW'($urandom_range(0, 3));
         writeregW = REG_AW'($urandom_range(0, 3));
         regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
         memtoRegE = 1'($urandom); memtoRegM = ($urandom_range(0, 2) == 0);
         memWriteM = ($urandom_range(0, 3) == 0); jumpD = ($urandom_range(0, 3) == 0);
         branchTakenM = ($urandom_range(0, 5) == 0); dmem_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (!rst) begin m_wait = 0; m_stalls = 0; m_flushes = 0; end
         exp = model_vec();
         n_checks++;
         if (obs_vec() !== exp) begin
            n_fail++; $display("FAIL random_outputs[%0d]: got %b expected %b", i, obs_vec(), exp);
         end
         n_checks++;
         if (dut_in_wait() !== m_wait) begin
            n_fail++; $display("FAIL random_state[%0d]: got %b expected %b", i, dut_in_wait(), m_wait);
         end
`ifdef HAZARD_PERF_EN
         n_checks++;
         if (stall_cycles !== m_stalls || flush_events !== m_flushes) begin
            n_fail++; $display("FAIL random_perf[%0d]: got %0d/%0d expected %0d/%0d", i, stall_cycles, flush_events, m_stalls, m_flushes);
         end
`endif
         // Effect of the coming rising edge on the model
         if (rst) begin
            if (!m_wait && (memtoRegM || memWriteM) && !dmem_ready) m_wait = 1;
            else if (m_wait && dmem_ready) m_wait = 0;
            if (exp[11:8] != 4'b0000) m_stalls++;
            if (exp[7] || exp[6]) m_flushes++;
         end
      end
      @(negedge clk); rst = 1; zero_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_forwarding();
      test_mem_wait();
      test_branch_priority();
      test_reset_in_wait();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
